risc_decode_stage: RTL and testbench

Registered RV32I/RV64I instruction decode stage sitting between fetch and execute. Accepts one fetched instruction per cycle over a valid/ready handshake and produces a decoded bundle: register indices, function fields, sign-extended immediate, write-enable and illegal flag. Parametrised in XLEN, so RV64 word-ops decode when XLEN=64. A two-entry skid buffer keeps full throughput while in_ready is a registered signal.

---
 rtl/risc_pkg.sv | 54 +++++
 rtl/risc_imm_gen.sv | 33 +++
 rtl/risc_decode_stage.sv | 186 ++++++++++++++++++
 tb/tb_risc_decode_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared decode types: opcodes, funct7 constants, immediate formats and the
// decoded bundle handed from decode to execute.
package risc_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [6:0] {
    OPCODE_LOAD       = 7'h03,
    OPCODE_MISC_MEM   = 7'h0F,
    OPCODE_I_ALU      = 7'h13,
    OPCODE_AUIPC      = 7'h17,
    OPCODE_I_ALU_32   = 7'h1B,
    OPCODE_STORE      = 7'h23,
    OPCODE_R_TYPE     = 7'h33,
    OPCODE_LUI        = 7'h37,
    OPCODE_R_TYPE_32  = 7'h3B,
    OPCODE_BRANCH     = 7'h63,
    OPCODE_JALR       = 7'h67,
    OPCODE_JAL        = 7'h6F,
    OPCODE_SYSTEM     = 7'h73
  } opcode_t;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  // pc/imm sized for the widest XLEN; the stage uses the low XLEN bits
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    opcode_t             opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [XLEN_MAX-1:0] imm;
    logic                rd_we;
    logic                illegal;
  } decoded_instr_t;

  function automatic logic writes_rd(input logic [6:0] op);
    return (op != OPCODE_STORE) && (op != OPCODE_BRANCH);
  endfunction

endpackage

// File: rtl/risc_imm_gen.sv
// Immediate extraction for the I/S/B/U/J formats, sign-extended to XLEN.
// Purely combinational.
module risc_imm_gen
  import risc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  imm_fmt_t        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (fmt_i)
      IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25],
                      instr_i[11:7]};
      IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm32 = {instr_i[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31],
                      instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/risc_decode_stage.sv
// RV32I/RV64I decode stage with a two-entry skid buffer.
// Define RISC_M_EXT_EN to accept funct7=0x01 M-extension ops.
module risc_decode_stage
  import risc_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output opcode_t         out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  logic     f7_ok, sh_ok, sh32_ok, ld_ok, st_ok, illegal;
  imm_fmt_t fmt;
  logic [XLEN-1:0] imm;
  decoded_instr_t  dec;

  risc_imm_gen #(.XLEN(XLEN)) u_imm (
    .instr_i (in_instr[31:7]),
    .fmt_i   (fmt),
    .imm_o   (imm)
  );

  always_comb begin
    f7_ok = 1'b0;
    unique case (1'b1)
      f7 == F7_BASE: f7_ok = 1'b1;
      f7 == F7_ALT:  f7_ok = (f3 == 3'b000) || (f3 == 3'b101);
`ifdef RISC_M_EXT_EN
      f7 == F7_MULDIV: f7_ok = 1'b1;
`endif
      default: f7_ok = 1'b0;
    endcase
  end

  // shift upper-field checks; word shifts always use a 5-bit shamt
  always_comb begin
    sh_ok   = 1'b1;
    sh32_ok = 1'b1;
    if (f3 == 3'b001) begin
      sh_ok   = RV64 ? (in_instr[31:26] == 6'h00) : (f7 == 7'h00);
      sh32_ok = (f7 == 7'h00);
    end else if (f3 == 3'b101) begin
      sh_ok   = RV64 ? (in_instr[31:26] == 6'h00 ||
                        in_instr[31:26] == 6'h10)
                     : (f7 == 7'h00 || f7 == 7'h20);
      sh32_ok = (f7 == 7'h00) || (f7 == 7'h20);
    end
  end

  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    unique case (f3)
      3'b000, 3'b001, 3'b010: begin ld_ok = 1'b1; st_ok = 1'b1; end
      3'b011:                 begin ld_ok = RV64; st_ok = RV64; end
      3'b100, 3'b101:         ld_ok = 1'b1;
      3'b110:                 ld_ok = RV64;
      default:                ;
    endcase
  end

  always_comb begin
    fmt     = IMM_NONE;
    illegal = 1'b0;
    case (op)
      OPCODE_LUI, OPCODE_AUIPC: fmt = IMM_U;
      OPCODE_JAL:               fmt = IMM_J;
      OPCODE_BRANCH:            fmt = IMM_B;
      OPCODE_JALR, OPCODE_MISC_MEM, OPCODE_SYSTEM: fmt = IMM_I;
      OPCODE_LOAD:  begin fmt = IMM_I; illegal = !ld_ok; end
      OPCODE_STORE: begin fmt = IMM_S; illegal = !st_ok; end
      OPCODE_I_ALU: begin fmt = IMM_I; illegal = !sh_ok; end
      OPCODE_I_ALU_32: begin
        fmt     = IMM_I;
        illegal = !RV64 || !sh32_ok;
      end
      OPCODE_R_TYPE:    illegal = !f7_ok;
      OPCODE_R_TYPE_32: illegal = !RV64 || !f7_ok;
      default:          illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) illegal = 1'b1;
  end

  always_comb begin
    dec         = '0;
    dec.pc      = XLEN_MAX'(in_pc);
    dec.opcode  = opcode_t'(op);
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.imm     = XLEN_MAX'(imm);
    dec.illegal = illegal;
    dec.rd_we   = !illegal && writes_rd(op) && (in_instr[11:7] != 5'd0);
  end

  decoded_instr_t main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic accept, drain;

  assign in_ready = !skid_v_q;
  assign accept   = in_valid && in_ready;
  assign drain    = main_v_q && out_ready;

  // skid only fills while main is held, so it always drains first
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    priority case (1'b1)
      skid_v_q && drain: begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
      accept && (!main_v_q || drain): begin
        main_d   = dec;
        main_v_d = 1'b1;
      end
      accept: begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end
      drain:   main_v_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (flush) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid   = main_v_q;
  assign out_pc      = main_q.pc[XLEN-1:0];
  assign out_opcode  = main_q.opcode;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_rd_we   = main_q.rd_we;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_risc_decode_stage.sv
// Directed bench for risc_decode_stage: decode vectors on XLEN=32 and
// XLEN=64 instances, then stall, flush and reset handling on the skid path.
module tb_risc_decode_stage;
  import risc_pkg::*;

`ifdef RISC_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        v32, rdy32, we32, ill32;
  logic [31:0] pc32, imm32;
  opcode_t     op32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32;
  logic [6:0]  f7_32;

  logic        v64, rdy64, we64, ill64;
  logic [63:0] pc64, imm64;
  opcode_t     op64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64;
  logic [6:0]  f7_64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risc_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(v32), .out_ready(out_ready),
    .out_pc(pc32), .out_opcode(op32),
    .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_funct3(f3_32), .out_funct7(f7_32),
    .out_imm(imm32), .out_rd_we(we32), .out_illegal(ill32)
  );

  risc_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(v64), .out_ready(out_ready),
    .out_pc(pc64), .out_opcode(op64),
    .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_funct3(f3_64), .out_funct7(f7_64),
    .out_imm(imm64), .out_rd_we(we64), .out_illegal(ill64)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    tick(); tick();
    chk("rst.valid",  v32,   0);
    chk("rst.ready",  rdy32, 1);
    chk("rst.pc",     pc32,  0);
    chk("rst.imm",    imm32, 0);
    chk("rst.rd",     rd32,  0);
    chk("rst.valid64", v64,  0);
    rst = 1'b0;
    tick();

    issue(32'h00500093, 64'h100);
    chk("addi.valid", v32, 1);
    chk("addi.pc",    pc32, 32'h100);
    chk("addi.op",    op32, 7'h13);
    chk("addi.rd",    rd32, 1);
    chk("addi.rs1",   rs1_32, 0);
    chk("addi.imm",   imm32, 5);
    chk("addi.we",    we32, 1);
    chk("addi.ill",   ill32, 0);

    issue(32'hFE20AE23, 64'h104);
    chk("sw.imm",  imm32, 32'hFFFFFFFC);
    chk("sw.rs2",  rs2_32, 2);
    chk("sw.rs1",  rs1_32, 1);
    chk("sw.f3",   f3_32, 3'b010);
    chk("sw.we",   we32, 0);
    chk("sw.imm64", imm64, 64'hFFFFFFFFFFFFFFFC);

    issue(32'hFE000CE3, 64'h108);
    chk("beq.imm", imm32, 32'hFFFFFFF8);
    chk("beq.we",  we32, 0);

    issue(32'h123452B7, 64'h10C);
    chk("lui.imm",   imm32, 32'h12345000);
    chk("lui.rd",    rd32, 5);
    chk("lui.we",    we32, 1);
    chk("lui.imm64", imm64, 64'h0000000012345000);

    issue(32'h800002B7, 64'hFFFF_0000_0000_0110);
    chk("lui8.imm",   imm32, 32'h80000000);
    chk("lui8.imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui8.pc64",  pc64,  64'hFFFF_0000_0000_0110);

    issue(32'h008000EF, 64'h114);
    chk("jal.imm", imm32, 8);
    chk("jal.we",  we32, 1);

    issue(32'h00000000, 64'h118);
    chk("zero.ill",   ill32, 1);
    chk("zero.we",    we32, 0);
    chk("zero.valid", v32, 1);

    issue(32'h022081B3, 64'h11C);
    chk("mul.ill", ill32, !M_EN);
    chk("mul.we",  we32, M_EN);
    chk("mul.rd",  rd32, 3);

    issue(32'h401080B3, 64'h120);
    chk("sub.ill", ill32, 0);
    chk("sub.we",  we32, 1);
    chk("sub.f7",  f7_32, 7'h20);

    issue(32'h401090B3, 64'h124);
    chk("alt_f3.ill", ill32, 1);
    chk("alt_f3.we",  we32, 0);

    issue(32'h4030D093, 64'h128);
    chk("srai.ill", ill32, 0);
    chk("srai.imm", imm32, 32'h403);

    issue(32'h02009093, 64'h12C);
    chk("slli32.ill", ill32, 1);
    chk("slli32.ill64", ill64, 0);

    issue(32'h00013083, 64'h130);
    chk("ld.ill32", ill32, 1);
    chk("ld.ill64", ill64, 0);
    chk("ld.we64",  we64, 1);

    issue(32'h0010809B, 64'h134);
    chk("addiw.ill32", ill32, 1);
    chk("addiw.ill64", ill64, 0);
    chk("addiw.imm64", imm64, 1);

    issue(32'h00500091, 64'h138);
    chk("lowbits.ill", ill32, 1);

    issue(32'h00000033, 64'h13C);
    chk("add_x0.ill", ill32, 0);
    chk("add_x0.we",  we32, 0);

    tick();
    chk("drain.valid", v32, 0);

    // stall: three instructions against a held output
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h200;
    chk("st.ready0", rdy32, 1);
    tick();
    chk("st.a_valid", v32, 1);
    chk("st.ready1", rdy32, 1);
    in_instr = 32'h00500113; in_pc = 64'h204;
    tick();
    chk("st.ready2", rdy32, 0);
    chk("st.hold_pc", pc32, 32'h200);
    in_instr = 32'h00500193; in_pc = 64'h208;
    tick();
    chk("st.ready3", rdy32, 0);
    chk("st.hold_pc2", pc32, 32'h200);
    out_ready = 1'b1;
    tick();
    chk("st.b_pc",    pc32, 32'h204);
    chk("st.b_rd",    rd32, 2);
    chk("st.b_valid", v32, 1);
    chk("st.ready4",  rdy32, 1);
    tick();
    in_valid = 1'b0;
    chk("st.c_pc",    pc32, 32'h208);
    chk("st.c_rd",    rd32, 3);
    chk("st.c_valid", v32, 1);
    tick();
    chk("st.empty", v32, 0);

    // flush with skid full and a simultaneous new instruction
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h300;
    tick();
    in_pc = 64'h304;
    tick();
    chk("fl.ready_pre", rdy32, 0);
    flush = 1'b1; in_pc = 64'h30C;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.valid", v32, 0);
    chk("fl.ready", rdy32, 1);
    out_ready = 1'b1;
    tick();
    chk("fl.still_empty", v32, 0);
    issue(32'h00500113, 64'h310);
    chk("fl.next_pc", pc32, 32'h310);
    tick();
    chk("fl.no_ghost", v32, 0);

    // reset mid-stall drops both entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h400;
    tick();
    in_pc = 64'h404;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs.valid", v32, 0);
    chk("rs.ready", rdy32, 1);
    chk("rs.pc",    pc32, 0);
    out_ready = 1'b1;
    tick();
    chk("rs.empty", v32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
